relu_seq_ctrl: RTL

Sequencer that streams a burst of MAC results through the registered ReLU stage and hands the rectified results downstream. It sits between the MAC array output and the layer writeback path. It drives the ReLU stage's data, enable, MAC-enable and bypass inputs. It tracks the stage's fixed 1-cycle latency and absorbs downstream backpressure in a 2-entry output buffer.

---
 rtl/relu_seq_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/relu_seq_ctrl.sv
// Burst sequencer around the registered ReLU stage with a 2-entry output FIFO.
// Optional negative-input statistics counter built only when RELU_SEQ_STATS_EN is defined.
module relu_seq_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    input  logic [CNT_W-1:0]  Len,
    input  logic              Mode_Bypass,
    input  logic              MAC_Valid,
    input  logic [DATA_W-1:0] MAC_Data,
    output logic              MAC_Ready,
    output logic [DATA_W-1:0] Data_Reg,
    output logic              En_ReLU,
    output logic              En_MAC_ReLU,
    output logic              BYPASS_ReLU,
    input  logic [DATA_W-1:0] ReLU_OUT,
    output logic              Out_Valid,
    output logic [DATA_W-1:0] Out_Data,
    input  logic              Out_Ready,
    output logic              Busy,
    output logic              Done,
    output logic [CNT_W-1:0]  Neg_Count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [CNT_W-1:0]         in_left;
    logic [CNT_W-1:0]         out_left;
    logic                     mode_byp;
    logic                     vld_p1;
    logic [1:0]               buf_occ;
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic signed [DATA_W-1:0] buf_mem [2];
    logic                     start_take;
    logic                     buf_vld;
    logic                     pop;
    logic [2:0]               pend;
    logic                     mac_ready;
    logic                     accept;

    assign start_take = (state == S_IDLE) && Start;
    assign buf_vld    = (buf_occ != 2'd0);
    assign pop        = buf_vld && Out_Ready;
    assign pend       = {1'b0, buf_occ} + {2'b00, vld_p1};
    // A pop in the same cycle frees a slot, so an unstalled burst keeps one beat per cycle.
    assign mac_ready  = (state == S_RUN) && (in_left != '0) && (pend < (3'd2 + {2'b00, pop}));
    assign accept     = MAC_Valid && mac_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (Start) state_nxt = (Len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accept && (in_left == CNT_W'(1))) state_nxt = S_DRAIN;
            S_DRAIN: if (pop && (out_left == CNT_W'(1))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        MAC_Ready   = mac_ready;
        Data_Reg    = '0;
        En_ReLU     = 1'b0;
        En_MAC_ReLU = 1'b0;
        Busy        = (state != S_IDLE);
        Done        = (state == S_DONE);
        BYPASS_ReLU = (state != S_IDLE) && mode_byp;
        if (accept) begin
            Data_Reg    = MAC_Data;
            En_ReLU     = 1'b1;
            En_MAC_ReLU = 1'b1;
        end
    end

    // p0: accept into the ReLU stage; p1: stage result returns and is captured
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            in_left  <= '0;
            out_left <= '0;
            mode_byp <= 1'b0;
            vld_p1   <= 1'b0;
            buf_occ  <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (start_take) begin
                in_left  <= Len;
                out_left <= Len;
                mode_byp <= Mode_Bypass;
            end else begin
                if (accept) in_left <= in_left - CNT_W'(1);
                if (pop)    out_left <= out_left - CNT_W'(1);
            end
            vld_p1 <= accept;
            if (vld_p1) wr_ptr <= ~wr_ptr;
            if (pop)    rd_ptr <= ~rd_ptr;
            buf_occ <= buf_occ + {1'b0, vld_p1} - {1'b0, pop};
        end
    end

    always_ff @(posedge CLK) begin
        if (vld_p1) buf_mem[wr_ptr] <= ReLU_OUT;
    end

    assign Out_Valid = buf_vld;
    assign Out_Data  = buf_vld ? buf_mem[rd_ptr] : '0;

`ifdef RELU_SEQ_STATS_EN
    logic [CNT_W-1:0] neg_cnt;

    function automatic logic is_negative(input logic signed [DATA_W-1:0] v);
        return v < 0;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_cnt <= '0;
        end else if (start_take) begin
            neg_cnt <= '0;
        end else if (accept && !mode_byp && is_negative(MAC_Data)) begin
            neg_cnt <= neg_cnt + CNT_W'(1);
        end
    end

    assign Neg_Count = neg_cnt;
`else
    assign Neg_Count = '0;
`endif

endmodule
